// File: rtl/dtm_jtag.sv
// dtm_jtag: RISC-V 0.13 JTAG debug transport module.
// Oversamples the JTAG pins in clk and issues one-cycle DMI requests.
module dtm_jtag #(
  parameter logic [31:0] IDCODE    = 32'h1000_0001,
  parameter int          RDATA_LAT = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        jtag_tck,
  input  logic        jtag_tms,
  input  logic        jtag_tdi,
  output logic        jtag_tdo,
  output logic        dmi_valid,
  output logic        dmi_wr,
  output logic [6:0]  dmi_addr,
  output logic [31:0] dmi_wdata,
  input  logic [31:0] dmi_rdata
);

  localparam int CW = $clog2(RDATA_LAT + 1) + 1;

  typedef enum logic [3:0] {
    TLR, RTI,
    SEL_DR, CAP_DR, SH_DR, EX1_DR,
    PA_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR,
    PA_IR, EX2_IR, UPD_IR
  } tap_t;

  typedef enum logic [1:0] {
    DR_IDC, DR_DTM, DR_DMI, DR_BYP
  } dr_t;

  logic [1:0]    r_tck_s;
  logic [1:0]    r_tms_s;
  logic [1:0]    r_tdi_s;
  logic          r_tck_p;
  tap_t          r_state;
  tap_t          w_next;
  logic [4:0]    r_ir;
  logic [4:0]    r_ir_sr;
  logic [40:0]   r_dr_sr;
  logic          r_tdo;
  logic [1:0]    r_dmistat;
  logic [6:0]    r_last_addr;
  logic [31:0]   r_last_rdata;
  logic          r_pend;
  logic          r_rd;
  logic [CW-1:0] r_cnt;
  logic          r_valid;
  logic          r_wr;
  logic [6:0]    r_addr;
  logic [31:0]   r_wdata;

  logic          w_rise;
  logic          w_fall;
  logic          w_tms;
  logic          w_tdi;
  dr_t           w_sel;
  logic [40:0]   w_dr_cap;
  logic [40:0]   w_dr_shf;
  logic          w_upd_dr;
  logic [1:0]    w_op;
  logic          w_dmi_ok;
  logic          w_busy;
  logic          w_issue;

  assign w_rise = r_tck_s[1] & ~r_tck_p;
  assign w_fall = ~r_tck_s[1] & r_tck_p;
  assign w_tms  = r_tms_s[1];
  assign w_tdi  = r_tdi_s[1];

  assign jtag_tdo  = r_tdo;
  assign dmi_valid = r_valid;
  assign dmi_wr    = r_wr;
  assign dmi_addr  = r_addr;
  assign dmi_wdata = r_wdata;

  // two-flop synchronisers plus a delayed tck for edge detection
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_tck_s <= '0;
      r_tms_s <= '0;
      r_tdi_s <= '0;
      r_tck_p <= 1'b0;
    end else begin
      r_tck_s <= {r_tck_s[0], jtag_tck};
      r_tms_s <= {r_tms_s[0], jtag_tms};
      r_tdi_s <= {r_tdi_s[0], jtag_tdi};
      r_tck_p <= r_tck_s[1];
    end
  end

  // TAP state register
  always_ff @(posedge clk) begin
    if (!resetn) r_state <= TLR;
    else         r_state <= w_next;
  end

  // TAP next state, advancing only on a synced tck rise
  always_comb begin
    w_next = r_state;
    if (w_rise) begin
      unique case (r_state)
        TLR:    w_next = w_tms ? TLR    : RTI;
        RTI:    w_next = w_tms ? SEL_DR : RTI;
        SEL_DR: w_next = w_tms ? SEL_IR : CAP_DR;
        CAP_DR: w_next = w_tms ? EX1_DR : SH_DR;
        SH_DR:  w_next = w_tms ? EX1_DR : SH_DR;
        EX1_DR: w_next = w_tms ? UPD_DR : PA_DR;
        PA_DR:  w_next = w_tms ? EX2_DR : PA_DR;
        EX2_DR: w_next = w_tms ? UPD_DR : SH_DR;
        UPD_DR: w_next = w_tms ? SEL_DR : RTI;
        SEL_IR: w_next = w_tms ? TLR    : CAP_IR;
        CAP_IR: w_next = w_tms ? EX1_IR : SH_IR;
        SH_IR:  w_next = w_tms ? EX1_IR : SH_IR;
        EX1_IR: w_next = w_tms ? UPD_IR : PA_IR;
        PA_IR:  w_next = w_tms ? EX2_IR : PA_IR;
        EX2_IR: w_next = w_tms ? UPD_IR : SH_IR;
        UPD_IR: w_next = w_tms ? SEL_DR : RTI;
        default: w_next = TLR;
      endcase
    end
  end

  // DR selection plus capture and shift values for the selected width
  always_comb begin
    w_sel = DR_BYP;
    unique case (1'b1)
      (r_ir == 5'h01): w_sel = DR_IDC;
      (r_ir == 5'h10): w_sel = DR_DTM;
      (r_ir == 5'h11): w_sel = DR_DMI;
      default:         w_sel = DR_BYP;
    endcase
    w_dr_cap = '0;
    w_dr_shf = {40'b0, w_tdi};
    unique case (w_sel)
      DR_IDC: begin
        w_dr_cap = {9'b0, IDCODE};
        w_dr_shf = {9'b0, w_tdi, r_dr_sr[31:1]};
      end
      DR_DTM: begin
        w_dr_cap = {9'b0, 14'b0, 3'b0, 3'd1,
                    r_dmistat, 6'd7, 4'd1};
        w_dr_shf = {9'b0, w_tdi, r_dr_sr[31:1]};
      end
      DR_DMI: begin
        w_dr_cap = {r_last_addr, r_last_rdata, r_dmistat};
        w_dr_shf = {w_tdi, r_dr_sr[40:1]};
      end
      default: begin
        w_dr_cap = '0;
        w_dr_shf = {40'b0, w_tdi};
      end
    endcase
  end

  assign w_upd_dr = w_fall && (r_state == UPD_DR);
  assign w_op     = r_dr_sr[1:0];
  assign w_dmi_ok = w_upd_dr && (w_sel == DR_DMI) &&
                    (r_dmistat == 2'd0);
  assign w_busy   = w_dmi_ok && r_pend;
  assign w_issue  = w_dmi_ok && !r_pend &&
                    ((w_op == 2'd1) || (w_op == 2'd2));

  // IR, shift registers and TDO driven on the synced tck edges
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_ir    <= 5'h01;
      r_ir_sr <= '0;
      r_dr_sr <= '0;
      r_tdo   <= 1'b0;
    end else begin
      if (r_state == TLR)
        r_ir <= 5'h01;
      else if (w_fall && (r_state == UPD_IR))
        r_ir <= r_ir_sr;
      if (w_rise) begin
        if (r_state == CAP_IR) r_ir_sr <= 5'b00001;
        if (r_state == SH_IR)  r_ir_sr <= {w_tdi, r_ir_sr[4:1]};
        if (r_state == CAP_DR) r_dr_sr <= w_dr_cap;
        if (r_state == SH_DR)  r_dr_sr <= w_dr_shf;
      end
      if (w_fall) begin
        if (r_state == SH_IR)      r_tdo <= r_ir_sr[0];
        else if (r_state == SH_DR) r_tdo <= r_dr_sr[0];
        else                       r_tdo <= 1'b0;
      end
    end
  end

  // DMI request issue, pending window and read-data latch
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_dmistat    <= 2'd0;
      r_last_addr  <= '0;
      r_last_rdata <= '0;
      r_pend       <= 1'b0;
      r_rd         <= 1'b0;
      r_cnt        <= '0;
      r_valid      <= 1'b0;
      r_wr         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else begin
      r_valid <= 1'b0;
      if (w_upd_dr && (w_sel == DR_DTM) && r_dr_sr[16])
        r_dmistat <= 2'd0;
      if (w_busy)
        r_dmistat <= 2'd3;
      if (w_issue) begin
        r_valid     <= 1'b1;
        r_wr        <= (w_op == 2'd2);
        r_addr      <= r_dr_sr[40:34];
        r_last_addr <= r_dr_sr[40:34];
        if (w_op == 2'd2) r_wdata <= r_dr_sr[33:2];
        r_pend      <= 1'b1;
        r_rd        <= (w_op == 2'd1);
        r_cnt       <= '0;
      end else if (r_pend) begin
        if (r_cnt == CW'(RDATA_LAT)) begin
          r_pend <= 1'b0;
          if (r_rd) r_last_rdata <= dmi_rdata;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

endmodule
